pio_wmem_initiator: RTL and testbench



---
 rtl/pio_wmem_initiator_if.sv | 35 +++
 rtl/pio_wmem_initiator.sv | 150 +++++++++++++++
 tb/tb_pio_wmem_initiator.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_wmem_initiator_if.sv
// Bundle for a wide-memory PIO initiator: app request/response side plus the 32-bit PIO bus.
// master = the initiator, slave = app + responder seen from outside.
interface pio_wmem_initiator_if #(
    parameter int WIDTH       = 40,
    parameter int DEPTH_NBITS = 10,
    parameter int PIO_NBITS   = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_wr;
    logic [DEPTH_NBITS-1:0] req_idx;
    logic [WIDTH-1:0]       req_wdata;
    logic                   rsp_valid;
    logic                   rsp_err;
    logic [WIDTH-1:0]       rsp_rdata;
    logic [PIO_NBITS-1:0]   reg_addr;
    logic [PIO_NBITS-1:0]   reg_din;
    logic                   reg_rd;
    logic                   reg_wr;
    logic                   reg_ms;
    logic                   mem_ack;
    logic [PIO_NBITS-1:0]   mem_rdata;

    modport master (
        input  req_valid, req_wr, req_idx, req_wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
               reg_addr, reg_din, reg_rd, reg_wr, reg_ms
    );

    modport slave (
        output req_valid, req_wr, req_idx, req_wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
               reg_addr, reg_din, reg_rd, reg_wr, reg_ms
    );
endinterface

// File: rtl/pio_wmem_initiator.sv
// Splits one wide (33..64-bit) request into two 32-bit PIO accesses (LSB dword, then MSB dword),
// reassembles read data and reports completion or ack timeout.
module pio_wmem_initiator #(
    parameter int          WIDTH       = 40,
    parameter int          DEPTH_NBITS = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          TIMEOUT_CYC = 256
) (
    input logic                  clk,
    input logic                  rst_n,
    pio_wmem_initiator_if.master bus
);
    localparam int PIO_NBITS = 32;
    localparam int CNT_W     = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {IDLE, ISS_L, WAIT_L, GAP_L, ISS_M, WAIT_M, GAP_M} state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_wr;
    logic [DEPTH_NBITS-1:0] r_idx;
    logic [PIO_NBITS-1:0]   r_wdata_hi;
    logic [PIO_NBITS-1:0]   r_lsb;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic                   r_rsp_err;
    logic [WIDTH-1:0]       r_rsp_rdata;
    logic [PIO_NBITS-1:0]   r_addr;
    logic [PIO_NBITS-1:0]   r_din;
    logic                   r_reg_rd;
    logic                   r_reg_wr;
    logic                   r_reg_ms;

    logic                   w_accept;
    logic                   w_tmo;
    logic [PIO_NBITS-1:0]   w_addr_l;
    logic [PIO_NBITS-1:0]   w_addr_m;

    assign w_accept = bus.req_valid & r_req_ready;
    assign w_tmo    = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_addr_l = BASE_ADDR + PIO_NBITS'({bus.req_idx, 3'b000});
    assign w_addr_m = BASE_ADDR + PIO_NBITS'({r_idx, 3'b100});

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_din   = r_din;
    assign bus.reg_rd    = r_reg_rd;
    assign bus.reg_wr    = r_reg_wr;
    assign bus.reg_ms    = r_reg_ms;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_idx       <= '0;
            r_wdata_hi  <= '0;
            r_lsb       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_reg_rd    <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_reg_ms    <= 1'b0;
        end else begin
            // strobes and the completion pulse are single-cycle unless re-armed below
            r_rsp_valid <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_reg_ms    <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_req_ready <= 1'b0;
                    r_wr        <= bus.req_wr;
                    r_idx       <= bus.req_idx;
                    r_wdata_hi  <= PIO_NBITS'(bus.req_wdata >> 32);
                    r_reg_ms    <= 1'b1;
                    r_reg_wr    <= bus.req_wr;
                    r_reg_rd    <= ~bus.req_wr;
                    r_addr      <= w_addr_l;
                    r_din       <= bus.req_wr ? bus.req_wdata[31:0] : '0;
                    r_state     <= ISS_L;
                end
                ISS_L: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_L;
                end
                WAIT_L: if (bus.mem_ack) begin
                    if (!r_wr) r_lsb <= bus.mem_rdata;
                    r_cnt   <= '0;
                    r_state <= GAP_L;
                end else if (w_tmo) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_cnt       <= '0;
                    r_state     <= GAP_M;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                // a stretched ack must fall before the next phase, or we give up waiting
                GAP_L: if (!bus.mem_ack || w_tmo) begin
                    r_reg_ms <= 1'b1;
                    r_reg_wr <= r_wr;
                    r_reg_rd <= ~r_wr;
                    r_addr   <= w_addr_m;
                    r_din    <= r_wr ? r_wdata_hi : '0;
                    r_state  <= ISS_M;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                ISS_M: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_M;
                end
                WAIT_M: if (bus.mem_ack) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    if (!r_wr) r_rsp_rdata <= WIDTH'({bus.mem_rdata, r_lsb});
                    r_cnt   <= '0;
                    r_state <= GAP_M;
                end else if (w_tmo) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_cnt       <= '0;
                    r_state     <= GAP_M;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                GAP_M: if (!bus.mem_ack || w_tmo) begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pio_wmem_initiator.sv
// Randomized bench for pio_wmem_initiator: wide-memory reference model, PIO responder,
// and scoreboards for PIO accesses, responses and latency.
module tb_pio_wmem_initiator;
    localparam int          WIDTH       = 40;
    localparam int          DEPTH_NBITS = 10;
    localparam int          TMO         = 8;
    localparam logic [31:0] BASE        = 32'h0000_4000;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
    } pio_t;

    typedef struct {
        logic             err;
        logic [WIDTH-1:0] rdata;
        int               lat;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pio_wmem_initiator_if #(.WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS), .PIO_NBITS(32)) bus ();

    pio_wmem_initiator #(
        .WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    pio_t             pio_q[$];
    rsp_t             rsp_q[$];
    int               acc_q[$];
    int               n_pass = 0, n_tot = 0;
    int               cyc = 0, n_acc = 0, n_iss = 0, m_strobes = 0;
    logic [WIDTH-1:0] ref_mem [int];
    logic [31:0]      resp_mem [int];
    logic [WIDTH-1:0] last_rdata = '0;

    // responder knobs, changed only while the DUT is idle
    int r_delay = 1, r_hold_l = 1, r_hold_m = 1;
    bit r_ack_l = 1'b1, r_ack_m = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // PIO responder: ack after r_delay cycles, held r_hold_x cycles; garbage above WIDTH in MSB reads
    initial begin
        logic [31:0] a, d;
        int          hold;
        bit          en;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.reg_ms && (bus.reg_rd || bus.reg_wr)) begin
                a = bus.reg_addr;
                if (bus.reg_wr) resp_mem[int'(a)] = bus.reg_din;
                en   = a[2] ? r_ack_m : r_ack_l;
                hold = a[2] ? r_hold_m : r_hold_l;
                if (en) begin
                    d = resp_mem.exists(int'(a)) ? resp_mem[int'(a)] : 32'h0;
                    if (a[2]) d = d | ($urandom << (WIDTH - 32));
                    repeat (r_delay) @(negedge clk);
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = d;
                    repeat (hold) @(negedge clk);
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end
        end
    end

    // PIO access monitor
    initial begin
        bit   prev, s;
        pio_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) prev = 1'b0;
            else begin
                s = bus.reg_rd || bus.reg_wr || bus.reg_ms;
                if (s) begin
                    chk("strobe_one_cycle", 64'(prev), 64'd0);
                    chk("ack_low_at_strobe", 64'(bus.mem_ack), 64'd0);
                    chk("ms_and_one_strobe", {62'd0, bus.reg_ms, bus.reg_rd ^ bus.reg_wr}, 64'd3);
                    if (bus.reg_addr[2]) m_strobes++;
                    if (pio_q.size() == 0) begin
                        n_tot++;
                        $display("FAIL pio_unexpected: access at %0h, none expected", bus.reg_addr);
                    end else begin
                        e = pio_q.pop_front();
                        chk("pio_addr", 64'(bus.reg_addr), 64'(e.addr));
                        chk("pio_wr", 64'(bus.reg_wr), 64'(e.wr));
                        chk("pio_din", 64'(bus.reg_din), 64'(e.din));
                    end
                end
                prev = s;
            end
        end
    end

    // accept monitor
    initial forever begin
        @(negedge clk); #1;
        if (rst_n && bus.req_valid && bus.req_ready) begin
            acc_q.push_back(cyc);
            n_acc++;
        end
    end

    // response monitor
    initial begin
        rsp_t e;
        int   a;
        forever begin
            @(negedge clk); #1;
            if (rst_n && bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL rsp_unexpected: rsp_valid with err=%0d, none expected", bus.rsp_err);
                end else begin
                    e = rsp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    chk("rsp_latency", 64'(cyc - a), 64'(e.lat));
                end
            end
        end
    end

    task automatic preload(int idx, logic [WIDTH-1:0] v);
        logic [63:0] w;
        w = 64'(v);
        ref_mem[idx] = v;
        resp_mem[int'(BASE) + idx * 8]     = 32'(w % 64'h1_0000_0000);
        resp_mem[int'(BASE) + idx * 8 + 4] = 32'(w / 64'h1_0000_0000);
    endtask

    // Reference model: a wide word memory; each request is two dword accesses at idx*8 and idx*8+4.
    task automatic issue(bit wr, int idx, logic [WIDTH-1:0] wd, bit ack_l, bit ack_m,
                         int dly, int hl, int hm, bit keep);
        int          guard;
        logic [63:0] w;
        logic [31:0] a;
        rsp_t        r;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!bus.req_ready && guard < 300);
        if (!bus.req_ready) begin
            n_tot++;
            $display("FAIL req_ready_wait: req_ready still %0d after %0d cycles", bus.req_ready, guard);
        end
        r_delay = dly; r_hold_l = hl; r_hold_m = hm; r_ack_l = ack_l; r_ack_m = ack_m;
        bus.req_wr = wr; bus.req_idx = DEPTH_NBITS'(idx); bus.req_wdata = wd; bus.req_valid = 1'b1;
        w = 64'(wd);
        a = BASE + 32'(idx) * 8;
        pio_q.push_back('{wr, a, wr ? 32'(w % 64'h1_0000_0000) : 32'h0});
        if (ack_l) pio_q.push_back('{wr, a + 4, wr ? 32'(w / 64'h1_0000_0000) : 32'h0});
        if (!ack_l) begin
            r = '{1'b1, '0, 2 + TMO};
        end else if (!ack_m) begin
            r = '{1'b1, '0, 3 + dly + hl + TMO};
        end else begin
            r.err = 1'b0;
            r.lat = 3 + 2 * dly + hl;
            if (wr) begin
                r.rdata = last_rdata;
                ref_mem[idx] = wd;
            end else begin
                r.rdata = ref_mem.exists(idx) ? ref_mem[idx] : '0;
            end
        end
        rsp_q.push_back(r);
        last_rdata = r.rdata;
        n_iss++;
        @(posedge clk); #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        chk({tag, "_strobes"}, {61'd0, bus.reg_rd, bus.reg_wr, bus.reg_ms}, 64'd0);
        chk({tag, "_reg_addr"}, 64'(bus.reg_addr), 64'd0);
        chk({tag, "_reg_din"}, 64'(bus.reg_din), 64'd0);
    endtask

    initial begin
        logic [63:0] r64;
        int          guard, m0, dly, hl, hm, idx;
        bit          wr, tmo, tmo_l;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_idx = '0; bus.req_wdata = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // directed: spec write/read examples with 1-cycle ack
        issue(1'b1, 5, 40'hAB_1234_5678, 1, 1, 1, 1, 1, 0);
        preload(3, 40'hC5_DEADBEEF);
        issue(1'b0, 3, '0, 1, 1, 1, 1, 1, 0);
        // ack stretched 4 cycles in both phases
        issue(1'b0, 3, '0, 1, 1, 1, 4, 4, 0);
        // no ack: abort after TMO wait cycles, then a normal request
        issue(1'b0, 7, '0, 0, 1, 1, 1, 1, 0);
        issue(1'b0, 5, '0, 1, 1, 1, 1, 1, 0);
        // MSB phase never acked
        issue(1'b0, 3, '0, 1, 0, 2, 1, 1, 0);
        // MSB ack stuck past the timeout: GAP exit forced, only one response
        issue(1'b0, 5, '0, 1, 1, 1, 1, 12, 0);
        repeat (16) @(negedge clk);

        // reset while waiting for the MSB ack; the late ack then lands in IDLE
        preload(0, 40'h3C_0BAD_F00D);
        m0 = m_strobes;
        issue(1'b0, 0, '0, 1, 1, 6, 1, 3, 0);
        guard = 0;
        while (m_strobes == m0 && guard < 100) begin @(negedge clk); guard++; end
        chk("msb_strobe_seen", 64'(m_strobes - m0), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        if (rsp_q.size() != 0) void'(rsp_q.pop_back());
        if (acc_q.size() != 0) void'(acc_q.pop_back());
        last_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(1'b0, 0, '0, 1, 1, 1, 1, 1, 0);

        // three reads with req_valid held high throughout
        preload(8, 40'h11_2222_3333);
        preload(9, 40'h44_5555_6666);
        preload(10, 40'h77_8888_9999);
        issue(1'b0, 8, '0, 1, 1, 1, 1, 1, 1);
        issue(1'b0, 9, '0, 1, 1, 1, 1, 1, 1);
        issue(1'b0, 10, '0, 1, 1, 1, 1, 1, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom_range(0, 1));
            idx   = $urandom_range(0, 15);
            r64   = {$urandom, $urandom};
            dly   = $urandom_range(1, 3);
            hl    = $urandom_range(1, 4);
            hm    = $urandom_range(1, 4);
            tmo   = !wr && ($urandom_range(0, 7) == 0);
            tmo_l = 1'($urandom_range(0, 1));
            issue(wr, idx, WIDTH'(r64), !(tmo && tmo_l), !(tmo && !tmo_l), dly, hl, hm, 0);
        end

        guard = 0;
        while ((rsp_q.size() != 0 || pio_q.size() != 0) && guard < 500) begin
            @(negedge clk); guard++;
        end
        chk("drain_rsp_pending", 64'(rsp_q.size()), 64'd0);
        chk("drain_pio_pending", 64'(pio_q.size()), 64'd0);
        chk("accept_count", 64'(n_acc), 64'(n_iss));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
